// File: rtl/countdown_display.sv
// Seven-segment countdown display: loads an interval, counts it down on 1 Hz ticks,
// shows 0 for two ticks, then blanks. Optional walk-lamp blink: define WALK_BLINK_EN.
module countdown_display (
  input  logic       clk,
  input  logic       sys_reset,
  input  logic       start_timer,
  input  logic [3:0] time_value,
  input  logic       one_hz_enable,
  input  logic       expired,
  input  logic       walk,
  output logic [6:0] seg,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] remaining_q, remaining_d;
  logic       hold_cnt_q, hold_cnt_d;
  logic [6:0] seg_q, seg_d;
  logic       busy_q, busy_d;
  logic       phase_d;
`ifdef WALK_BLINK_EN
  logic       phase_q;
`else
  logic       unused_walk;
  assign unused_walk = walk;
`endif

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    hold_cnt_d  = hold_cnt_q;
`ifdef WALK_BLINK_EN
    phase_d     = phase_q;
`else
    phase_d     = 1'b0;
`endif
    if (start_timer) begin
      remaining_d = time_value;
      hold_cnt_d  = 1'b0;
      phase_d     = 1'b0;
      state_d     = (time_value != 4'd0) ? COUNT : DONE;
    end else begin
      case (state_q)
        COUNT: begin
          if (expired) begin
            remaining_d = 4'd0;
            hold_cnt_d  = 1'b0;
            phase_d     = 1'b0;
            state_d     = DONE;
          end else begin
`ifdef WALK_BLINK_EN
            // Blink phase advances on ticks taken at 3 or below, current value.
            if (!walk)
              phase_d = 1'b0;
            else if (one_hz_enable && remaining_q <= 4'd3)
              phase_d = ~phase_q;
`endif
            if (one_hz_enable) begin
              if (remaining_q != 4'd0)
                remaining_d = remaining_q - 4'd1;
              if (remaining_q <= 4'd1) begin
                hold_cnt_d = 1'b0;
                phase_d    = 1'b0;
                state_d    = DONE;
              end
            end
          end
        end
        DONE: begin
          if (one_hz_enable) begin
            if (hold_cnt_q) begin
              hold_cnt_d = 1'b0;
              state_d    = IDLE;
            end else begin
              hold_cnt_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    // Outputs are registered from next state so they track the state register.
    busy_d = (state_d == COUNT);
    if (state_d == IDLE || phase_d)
      seg_d = 7'h00;
    else
      seg_d = hex7(remaining_d);
  end

  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q     <= IDLE;
      remaining_q <= 4'd0;
      hold_cnt_q  <= 1'b0;
      seg_q       <= 7'h00;
      busy_q      <= 1'b0;
`ifdef WALK_BLINK_EN
      phase_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      hold_cnt_q  <= hold_cnt_d;
      seg_q       <= seg_d;
      busy_q      <= busy_d;
`ifdef WALK_BLINK_EN
      phase_q     <= phase_d;
`endif
    end
  end

  assign seg  = seg_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_countdown_display.sv
// Bench for countdown_display: fixed vector table, hand sequences, random vs. reference model.
module tb_countdown_display;

  logic       clk = 1'b0;
  logic       sys_reset;
  logic       start_timer;
  logic [3:0] time_value;
  logic       one_hz_enable;
  logic       expired;
  logic       walk;
  logic [6:0] seg;
  logic       busy;

  countdown_display dut (
    .clk(clk), .sys_reset(sys_reset), .start_timer(start_timer), .time_value(time_value),
    .one_hz_enable(one_hz_enable), .expired(expired), .walk(walk), .seg(seg), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: mode 0=blank, 1=counting, 2=showing zero; ticks_seen in zero-display.
  int mode, rem, ticks_seen, blank_ph;

  task automatic model_reset();
    mode = 0; rem = 0; ticks_seen = 0; blank_ph = 0;
  endtask

  task automatic model_clock(input bit st, input int tv, input bit tk, input bit ex, input bit wk);
    if (st) begin
      rem = tv; blank_ph = 0; ticks_seen = 0;
      mode = (tv == 0) ? 2 : 1;
    end else if (mode == 1) begin
      if (ex) begin
        rem = 0; mode = 2; ticks_seen = 0; blank_ph = 0;
      end else begin
`ifdef WALK_BLINK_EN
        if (!wk) blank_ph = 0;
        else if (tk && rem <= 3) blank_ph = 1 - blank_ph;
`endif
        if (tk) begin
          rem = (rem > 0) ? rem - 1 : 0;
          if (rem == 0) begin mode = 2; ticks_seen = 0; blank_ph = 0; end
        end
      end
    end else if (mode == 2 && tk) begin
      ticks_seen++;
      if (ticks_seen == 2) mode = 0;
    end
  endtask

  function automatic logic [6:0] model_seg();
    if (mode == 0 || blank_ph != 0) return 7'h00;
    return lut[rem];
  endfunction

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic step(input bit st, input logic [3:0] tv, input bit tk, input bit ex, input bit wk);
    start_timer = st; time_value = tv; one_hz_enable = tk; expired = ex; walk = wk;
    @(posedge clk);
    model_clock(st, int'(tv), tk, ex, wk);
    #1;
    check("model_seg", seg, model_seg());
    check("model_busy", {6'd0, busy}, {6'd0, (mode == 1)});
  endtask

  typedef struct {
    bit st; logic [3:0] tv; bit tk; bit ex; logic [6:0] seg; bit busy;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit st, logic [3:0] tv, bit tk, bit ex, logic [6:0] s, bit b);
    vec_t v;
    v.st = st; v.tv = tv; v.tk = tk; v.ex = ex; v.seg = s; v.busy = b;
    return v;
  endfunction

  initial begin
    // load 5, count down, hold zero two ticks, blank
    tbl.push_back(mk(1, 5, 0, 0, 7'h6D, 1));
    tbl.push_back(mk(0, 0, 1, 0, 7'h66, 1));
    tbl.push_back(mk(0, 0, 0, 0, 7'h66, 1));
    tbl.push_back(mk(0, 0, 1, 0, 7'h4F, 1));
    tbl.push_back(mk(0, 0, 1, 0, 7'h5B, 1));
    tbl.push_back(mk(0, 0, 1, 0, 7'h06, 1));
    tbl.push_back(mk(0, 0, 1, 0, 7'h3F, 0));
    tbl.push_back(mk(0, 0, 1, 0, 7'h3F, 0));
    tbl.push_back(mk(0, 0, 0, 0, 7'h3F, 0));
    tbl.push_back(mk(0, 0, 1, 0, 7'h00, 0));
    tbl.push_back(mk(0, 0, 1, 0, 7'h00, 0));
    // zero-length interval goes straight to the zero display
    tbl.push_back(mk(1, 0, 0, 0, 7'h3F, 0));
    tbl.push_back(mk(0, 0, 1, 0, 7'h3F, 0));
    tbl.push_back(mk(0, 0, 1, 0, 7'h00, 0));
    // load beats a simultaneous tick
    tbl.push_back(mk(1, 4, 0, 0, 7'h66, 1));
    tbl.push_back(mk(1, 9, 1, 0, 7'h6F, 1));
    tbl.push_back(mk(0, 0, 1, 0, 7'h7F, 1));
    // expiry forces zero
    tbl.push_back(mk(1, 7, 0, 0, 7'h07, 1));
    tbl.push_back(mk(0, 0, 0, 1, 7'h3F, 0));
    tbl.push_back(mk(0, 0, 0, 0, 7'h3F, 0));
    // restart from the zero display wins over the return to blank
    tbl.push_back(mk(0, 0, 1, 0, 7'h3F, 0));
    tbl.push_back(mk(1, 2, 1, 0, 7'h5B, 1));
    tbl.push_back(mk(0, 0, 1, 0, 7'h06, 1));
    tbl.push_back(mk(0, 0, 1, 0, 7'h3F, 0));
    tbl.push_back(mk(1, 15, 0, 0, 7'h71, 1));
    tbl.push_back(mk(0, 0, 0, 1, 7'h3F, 0));
    tbl.push_back(mk(0, 0, 1, 0, 7'h3F, 0));
    tbl.push_back(mk(0, 0, 1, 0, 7'h00, 0));

    start_timer = 0; time_value = 0; one_hz_enable = 0; expired = 0; walk = 0;
    sys_reset = 1;
    model_reset();
    #12;
    check("reset_seg", seg, 7'h00);
    check("reset_busy", {6'd0, busy}, 7'd0);
    sys_reset = 0;
    #5;

    foreach (tbl[i]) begin
      step(tbl[i].st, tbl[i].tv, tbl[i].tk, tbl[i].ex, 1'b0);
      check($sformatf("vec%0d_seg", i), seg, tbl[i].seg);
      check($sformatf("vec%0d_busy", i), {6'd0, busy}, {6'd0, tbl[i].busy});
    end

    // asynchronous reset mid-count at 6
    step(1, 6, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("pre_reset_seg", seg, 7'h7D);
    #3 sys_reset = 1;
    #1;
    check("async_reset_seg", seg, 7'h00);
    check("async_reset_busy", {6'd0, busy}, 7'd0);
    model_reset();
    #1 sys_reset = 0;
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check("post_reset_seg", seg, 7'h00);

    // walk blink on a 3-second interval
    step(1, 3, 0, 0, 1);
    check("blink_load", seg, 7'h4F);
    step(0, 0, 1, 0, 1);
`ifdef WALK_BLINK_EN
    check("blink_t1", seg, 7'h00);
`else
    check("blink_t1", seg, 7'h5B);
`endif
    step(0, 0, 1, 0, 1);
    check("blink_t2", seg, 7'h06);
    step(0, 0, 1, 0, 1);
    check("blink_t3", seg, 7'h3F);
    check("blink_t3_busy", {6'd0, busy}, 7'd0);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
